// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - MIPS32 write-back select, 32x32 register file with write-through bypass, retired counter
module writeback_regfile #(
  parameter bit BYPASS_EN   = 1'b1,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   RegWrite_WB,
  input  logic                   MemtoReg_WB,
  input  logic [31:0]            Read_Data_WB,
  input  logic [31:0]            ALU_Result_WB,
  input  logic [4:0]             Write_Register_WB,
  input  logic [31:0]            Instruction_WB,
  input  logic [4:0]             Read_Register_1_ID,
  input  logic [4:0]             Read_Register_2_ID,
  output logic [31:0]            Read_Data_1_ID,
  output logic [31:0]            Read_Data_2_ID,
  output logic [31:0]            Write_Data_WB,
  output logic [COUNT_WIDTH-1:0] Retired_Count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]            regs [32];
  logic [COUNT_WIDTH-1:0] retired;
  logic                   commit;
  logic                   hit_1;
  logic                   hit_2;

  assign Write_Data_WB = MemtoReg_WB ? Read_Data_WB : ALU_Result_WB;
  assign commit        = RegWrite_WB && (Write_Register_WB != 5'd0);
  assign hit_1         = BYPASS_EN && commit && (Read_Register_1_ID == Write_Register_WB);
  assign hit_2         = BYPASS_EN && commit && (Read_Register_2_ID == Write_Register_WB);

  // Index 0 is forced to zero on read so r0 never depends on stored contents.
  always_comb begin
    Read_Data_1_ID = 32'd0;
    Read_Data_2_ID = 32'd0;
    if (Read_Register_1_ID != 5'd0) begin
      Read_Data_1_ID = hit_1 ? Write_Data_WB : regs[Read_Register_1_ID];
    end
    if (Read_Register_2_ID != 5'd0) begin
      Read_Data_2_ID = hit_2 ? Write_Data_WB : regs[Read_Register_2_ID];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      retired <= '0;
    end else begin
      if (commit) begin
        regs[Write_Register_WB] <= Write_Data_WB;
      end
      if (Instruction_WB != 32'd0) begin
        retired <= retired + COUNT_ONE;
      end
    end
  end

  assign Retired_Count = retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile (bypass and non-bypass instances)
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        RegWrite_WB = 1'b0;
  logic        MemtoReg_WB = 1'b0;
  logic [31:0] Read_Data_WB = 32'd0;
  logic [31:0] ALU_Result_WB = 32'd0;
  logic [4:0]  Write_Register_WB = 5'd0;
  logic [31:0] Instruction_WB = 32'd0;
  logic [4:0]  Read_Register_1_ID = 5'd0;
  logic [4:0]  Read_Register_2_ID = 5'd0;

  logic [31:0] a_rd1, a_rd2, a_wd, a_count;
  logic [31:0] b_rd1, b_rd2, b_wd;
  logic [3:0]  b_count;

  always #5 clk = ~clk;

  writeback_regfile #(.BYPASS_EN(1'b1), .COUNT_WIDTH(32)) dut_a (
    .Clk(clk), .Reset(Reset), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .Read_Data_WB(Read_Data_WB), .ALU_Result_WB(ALU_Result_WB),
    .Write_Register_WB(Write_Register_WB), .Instruction_WB(Instruction_WB),
    .Read_Register_1_ID(Read_Register_1_ID), .Read_Register_2_ID(Read_Register_2_ID),
    .Read_Data_1_ID(a_rd1), .Read_Data_2_ID(a_rd2), .Write_Data_WB(a_wd),
    .Retired_Count(a_count)
  );

  writeback_regfile #(.BYPASS_EN(1'b0), .COUNT_WIDTH(4)) dut_b (
    .Clk(clk), .Reset(Reset), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .Read_Data_WB(Read_Data_WB), .ALU_Result_WB(ALU_Result_WB),
    .Write_Register_WB(Write_Register_WB), .Instruction_WB(Instruction_WB),
    .Read_Register_1_ID(Read_Register_1_ID), .Read_Register_2_ID(Read_Register_2_ID),
    .Read_Data_1_ID(b_rd1), .Read_Data_2_ID(b_rd2), .Write_Data_WB(b_wd),
    .Retired_Count(b_count)
  );

  // Reference model: architectural register contents and number of retired instructions.
  logic [31:0] m_regs [32];
  int unsigned m_count;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp, input logic rw,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (byp && rw && wr == idx) return wd;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs and current state, then commit to model.
  task automatic cycle(input logic rst, input logic rw, input logic mtr,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [31:0] instr, input logic [4:0] r1, input logic [4:0] r2,
                       output logic [31:0] o1, output logic [31:0] o2);
    logic [31:0] wd;
    @(negedge clk);
    Reset = rst; RegWrite_WB = rw; MemtoReg_WB = mtr; Read_Data_WB = rd;
    ALU_Result_WB = alu; Write_Register_WB = wr; Instruction_WB = instr;
    Read_Register_1_ID = r1; Read_Register_2_ID = r2;
    #1;
    wd = mtr ? rd : alu;
    check("write_data_a", a_wd, wd);
    check("write_data_b", b_wd, wd);
    check("a_port1", a_rd1, exp_rd(r1, 1'b1, rw, wr, wd));
    check("a_port2", a_rd2, exp_rd(r2, 1'b1, rw, wr, wd));
    check("b_port1", b_rd1, exp_rd(r1, 1'b0, rw, wr, wd));
    check("b_port2", b_rd2, exp_rd(r2, 1'b0, rw, wr, wd));
    check("a_count", a_count, m_count);
    check("b_count", {28'd0, b_count}, m_count % 16);
    o1 = a_rd1;
    o2 = a_rd2;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rw && wr != 5'd0) m_regs[wr] = wd;
      if (instr != 32'd0) m_count = m_count + 1;
    end
  endtask

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] instr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [31:0] o1, o2;
    logic [4:0]  wr, r1, r2;
    logic        rst;

    tbl[0] = '{1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 32'h8C020004, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h12345678, 32'h0, 5'd5, 32'h1, 5'd5, 5'd5, 32'h12345678, 32'h12345678};
    tbl[3] = '{1'b1, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd9, 32'h0, 5'd5, 5'd9, 32'h12345678, 32'hA5A5A5A5};
    tbl[4] = '{1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 32'h2, 5'd0, 5'd9, 32'h0, 32'hA5A5A5A5};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9, 32'h0, 32'hA5A5A5A5};

    // Initial reset: power-up state is undefined, so nothing is checked until it completes.
    repeat (2) @(posedge clk);
    model_reset();

    // Every index reads zero on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'(i), 5'(31 - i), o1, o2);
      check("reset_read_p1", o1, 32'h0);
      check("reset_read_p2", o2, 32'h0);
    end

    // Directed vectors: write, load, bypass, r0 discard.
    foreach (tbl[k]) begin
      cycle(1'b0, tbl[k].rw, tbl[k].mtr, tbl[k].rd, tbl[k].alu, tbl[k].wr,
            tbl[k].instr, tbl[k].r1, tbl[k].r2, o1, o2);
      check($sformatf("vec%0d_p1", k), o1, tbl[k].e1);
      check($sformatf("vec%0d_p2", k), o2, tbl[k].e2);
    end

    // Non-bypass instance sees r9 only after the commit edge.
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h5A5A5A5A, 5'd9, 32'h0, 5'd9, 5'd9, o1, o2);
    #1;
    check("nobypass_next_cycle", b_rd2, 32'h5A5A5A5A);

    // Retirement: 10 cycles alternating bubble / load, RegWrite off.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, o1, o2);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, (i % 2 == 1) ? 32'h8C020004 : 32'h0,
            5'd1, 5'd2, o1, o2);
    end
    #1;
    check("retired_alt10", a_count, 32'd5);

    // 17 non-bubbles wrap the 4-bit counter to 1.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, o1, o2);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h8C020004, 5'd0, 5'd0, o1, o2);
    end
    #1;
    check("retired_wrap4", {28'd0, b_count}, 32'd1);
    check("retired_17", a_count, 32'd17);

    // Reset colliding with a write and a non-bubble; the following write commits normally.
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h76543210, 5'd3, 32'h1, 5'd3, 5'd0, o1, o2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 5'd3, 32'h8C020004, 5'd3, 5'd3, o1, o2);
    #1;
    check("midreset_r3_p1", b_rd1, 32'h0);
    check("midreset_count", a_count, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h11112222, 5'd3, 32'h0, 5'd3, 5'd3, o1, o2);
    check("postreset_bypass", o1, 32'h11112222);
    #1;
    check("postreset_commit", b_rd2, 32'h11112222);

    // Randomised traffic with occasional resets, reads biased toward the write index.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 40) == 0);
      wr  = 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      cycle(rst, 1'($urandom), 1'($urandom), $urandom, $urandom, wr,
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, r1, r2, o1, o2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and architectural register file for the MIPS32 five-stage pipeline. Consumes the WB-side outputs of the MEM/WB pipeline register, selects the write-back value, commits it to the 32×32 register file, and serves the two ID-stage read ports with same-cycle write-through bypass. Also maintains a retired-instruction counter for debug and performance observation.

## Interface
- BYPASS_EN, 1, 1 = ID reads of the register being written this cycle return the new value; 0 = they return the stored (old) value
- COUNT_WIDTH, 32, width of the retired-instruction counter
- Clk  input  1  global clock, all state updates on posedge
- Reset  input  1  synchronous, active-high; sampled on posedge Clk
- RegWrite_WB  input  1  write enable from MEM/WB
- MemtoReg_WB  input  1  1 = write Read_Data_WB, 0 = write ALU_Result_WB
- Read_Data_WB  input  32  load data from MEM/WB
- ALU_Result_WB  input  32  ALU result from MEM/WB
- Write_Register_WB  input  5  destination register index
- Instruction_WB  input  32  instruction word in WB; 32'd0 is a bubble
- Read_Register_1_ID  input  5  ID read port 1 index (rs)
- Read_Register_2_ID  input  5  ID read port 2 index (rt)
- Read_Data_1_ID  output  32  port 1 data, combinational
- Read_Data_2_ID  output  32  port 2 data, combinational
- Write_Data_WB  output  32  selected write-back value, combinational, for the forwarding unit
- Retired_Count  output  COUNT_WIDTH  number of non-bubble instructions that have left WB

## Operation
- Write_Data_WB = MemtoReg_WB ? Read_Data_WB : ALU_Result_WB, always driven, regardless of RegWrite_WB.
- Commit: on posedge Clk with Reset=0, if RegWrite_WB=1 and Write_Register_WB≠0, regs[Write_Register_WB] ← Write_Data_WB.
- Register 0 is hardwired to zero: writes to index 0 are discarded; reads of index 0 return 32'd0 on both ports, including under bypass.
- Read port n: if BYPASS_EN=1, RegWrite_WB=1, Write_Register_WB≠0 and Read_Register_n_ID = Write_Register_WB → Write_Data_WB; otherwise regs[Read_Register_n_ID].
- Both ports are independent. Same index on both ports returns identical data.
- Retired_Count increments by 1 on each posedge with Reset=0 and Instruction_WB≠32'd0, whether or not RegWrite_WB is set. It wraps modulo 2^COUNT_WIDTH without saturation or flag.
- Reset: all 32 registers ← 0 and Retired_Count ← 0. Reset takes priority over a simultaneous commit or count.
- Reset mid-stream: WB inputs present in the reset cycle are dropped, and no partial state persists. The first post-reset edge behaves normally.

## Timing
- Write latency: 1 cycle. Data presented in cycle N is visible from regs after posedge N.
- With BYPASS_EN=1, an ID read in cycle N of the register written in cycle N sees the new value with 0-cycle latency. This resolves the WB→ID hazard without a stall.
- Read ports and Write_Data_WB are purely combinational from inputs and register state; there are no added pipeline stages.
- Output values after Reset:
  - Read_Data_1_ID and Read_Data_2_ID = 0 for any index, until a write occurs.
  - Write_Data_WB follows the inputs.
  - Retired_Count = 0.
- Power-up before the first Reset is undefined for the verification model; bench must assert Reset for ≥1 cycle.

## Test plan
- Reset then read all 32 indices on both ports → every read returns 32'h00000000; Retired_Count = 0.
- Write ALU_Result_WB=32'hDEADBEEF to r5 (MemtoReg_WB=0), next cycle read r5 on port 1 → 32'hDEADBEEF; then load Read_Data_WB=32'h12345678 to r5 (MemtoReg_WB=1) → r5 = 32'h12345678.
- Same-cycle bypass, BYPASS_EN=1: RegWrite_WB=1 to r9 with 32'hA5A5A5A5, port 2 index 9 → port 2 = 32'hA5A5A5A5 in that cycle. With BYPASS_EN=0, the same stimulus gives the old r9 value in that cycle and 32'hA5A5A5A5 in the next.
- Write 32'hFFFFFFFF to r0, with and without bypass → r0 reads 0 in both cases; the write to index 0 is discarded.
- Drive 10 cycles alternating Instruction_WB = 32'h00000000 and 32'h8C020004, with RegWrite_WB=0 throughout → Retired_Count = 5. With COUNT_WIDTH=4 and 17 non-bubbles → Retired_Count = 1 (wrap).
- Assert Reset in the same cycle as a write of 32'h0BADF00D to r3 and a non-bubble instruction → r3 = 0 and Retired_Count = 0 afterwards. A write issued the next cycle commits normally.
